// File: rtl/fir_emu_pkg.sv
// rtl/fir_emu_pkg.sv - shared types, widths and wrapper address map for the FIR emulation master
package fir_emu_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 16;

  localparam logic [BYTE_W-1:0] ADDR_CIN     = 8'd0;
  localparam logic [BYTE_W-1:0] ADDR_XIN     = 8'd1;
  localparam logic [BYTE_W-1:0] ADDR_YHI     = 8'd2;
  localparam logic [BYTE_W-1:0] ADDR_YLO     = 8'd3;
  localparam logic [BYTE_W-1:0] ADDR_XOUT    = 8'd0;
  localparam logic [BYTE_W-1:0] ADDR_YOUT_HI = 8'd1;
  localparam logic [BYTE_W-1:0] ADDR_YOUT_LO = 8'd2;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR0,
    S_WR1,
    S_WR2,
    S_WR3,
    S_LOAD,
    S_DCLK,
    S_GET,
    S_RD0,
    S_RD1,
    S_RD2,
    S_CAP,
    S_DONE
  } state_t;

  // States that perform a two-cycle SETUP/STROBE wrapper access.
  function automatic logic is_access(state_t s);
    return s inside {S_WR0, S_WR1, S_WR2, S_WR3, S_LOAD, S_GET, S_RD0, S_RD1, S_RD2};
  endfunction

  function automatic state_t next_access(state_t s);
    case (s)
      S_WR0:   return S_WR1;
      S_WR1:   return S_WR2;
      S_WR2:   return S_WR3;
      S_WR3:   return S_LOAD;
      S_LOAD:  return S_DCLK;
      S_GET:   return S_RD0;
      S_RD0:   return S_RD1;
      S_RD1:   return S_RD2;
      S_RD2:   return S_CAP;
      default: return S_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/fir_emu_master_if.sv
// rtl/fir_emu_master_if.sv - transaction and wrapper-bus signals of the FIR emulation master
interface fir_emu_master_if;
  import fir_emu_pkg::*;

  logic              start;
  logic [BYTE_W-1:0] cin;
  logic [BYTE_W-1:0] xin;
  logic [WORD_W-1:0] yin;
  logic              ready;
  logic              done;
  logic [BYTE_W-1:0] xout;
  logic [WORD_W-1:0] yout;
  logic [BYTE_W-1:0] emu_data;
  logic [BYTE_W-1:0] emu_q;
  logic [BYTE_W-1:0] emu_addr;
  logic              emu_load;
  logic              emu_get;
  logic              emu_clk;
  logic              dut_clk;

  modport master (
    input  start, cin, xin, yin, emu_q,
    output ready, done, xout, yout, emu_data, emu_addr, emu_load, emu_get, emu_clk, dut_clk
  );

  modport slave (
    output start, cin, xin, yin, emu_q,
    input  ready, done, xout, yout, emu_data, emu_addr, emu_load, emu_get, emu_clk, dut_clk
  );

endinterface

// File: rtl/fir_emu_master.sv
// rtl/fir_emu_master.sv - sequences one FIR PE evaluation through the emulation wrapper
module fir_emu_master
  import fir_emu_pkg::*;
#(
  parameter int unsigned DUT_CYCLES = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  fir_emu_master_if.master        bus
);

  localparam logic [3:0] LAST_PULSE = 4'(DUT_CYCLES - 1);

  state_t            state, state_n;
  logic              phase, phase_n;
  logic [3:0]        dcnt, dcnt_n;
  logic [BYTE_W-1:0] lat_c, lat_c_n;
  logic [BYTE_W-1:0] lat_x, lat_x_n;
  logic [WORD_W-1:0] lat_y, lat_y_n;
  logic [BYTE_W-1:0] cap_x, cap_yhi;

  logic              ready_n, done_n, load_n, get_n, emu_clk_n, dut_clk_n;
  logic [BYTE_W-1:0] addr_n, data_n;

  always_comb begin
    state_n = state;
    phase_n = phase;
    dcnt_n  = dcnt;
    lat_c_n = lat_c;
    lat_x_n = lat_x;
    lat_y_n = lat_y;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          state_n = S_WR0;
          phase_n = 1'b0;
          lat_c_n = bus.cin;
          lat_x_n = bus.xin;
          lat_y_n = bus.yin;
        end
      end
      // phase 0 is the dut_clk-high half of each pulse
      S_DCLK: begin
        phase_n = ~phase;
        if (phase) begin
          if (dcnt == LAST_PULSE) begin
            state_n = S_GET;
            dcnt_n  = '0;
          end else begin
            dcnt_n = dcnt + 4'd1;
          end
        end
      end
      S_CAP:  state_n = S_DONE;
      S_DONE: state_n = S_IDLE;
      default: begin
        phase_n = ~phase;
        if (phase) state_n = next_access(state);
      end
    endcase
  end

  // Outputs are decoded from the next state so the registered values line up with it.
  always_comb begin
    addr_n    = '0;
    data_n    = '0;
    load_n    = (state_n == S_LOAD);
    get_n     = (state_n == S_GET);
    emu_clk_n = phase_n && is_access(state_n);
    dut_clk_n = (state_n == S_DCLK) && !phase_n;
    ready_n   = (state_n == S_IDLE);
    done_n    = (state_n == S_DONE);
    case (state_n)
      S_WR0: begin addr_n = ADDR_CIN; data_n = lat_c_n;               end
      S_WR1: begin addr_n = ADDR_XIN; data_n = lat_x_n;               end
      S_WR2: begin addr_n = ADDR_YHI; data_n = lat_y_n[WORD_W-1:8];   end
      S_WR3: begin addr_n = ADDR_YLO; data_n = lat_y_n[7:0];          end
      S_RD0: addr_n = ADDR_XOUT;
      S_RD1: addr_n = ADDR_YOUT_HI;
      S_RD2: addr_n = ADDR_YOUT_LO;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      phase        <= 1'b0;
      dcnt         <= '0;
      lat_c        <= '0;
      lat_x        <= '0;
      lat_y        <= '0;
      cap_x        <= '0;
      cap_yhi      <= '0;
      bus.ready    <= 1'b1;
      bus.done     <= 1'b0;
      bus.xout     <= '0;
      bus.yout     <= '0;
      bus.emu_data <= '0;
      bus.emu_addr <= '0;
      bus.emu_load <= 1'b0;
      bus.emu_get  <= 1'b0;
      bus.emu_clk  <= 1'b0;
      bus.dut_clk  <= 1'b0;
    end else begin
      state        <= state_n;
      phase        <= phase_n;
      dcnt         <= dcnt_n;
      lat_c        <= lat_c_n;
      lat_x        <= lat_x_n;
      lat_y        <= lat_y_n;
      bus.ready    <= ready_n;
      bus.done     <= done_n;
      bus.emu_data <= data_n;
      bus.emu_addr <= addr_n;
      bus.emu_load <= load_n;
      bus.emu_get  <= get_n;
      bus.emu_clk  <= emu_clk_n;
      bus.dut_clk  <= dut_clk_n;
      // The wrapper presents a read byte in the SETUP cycle after its STROBE.
      if (!phase && state == S_RD1) cap_x   <= bus.emu_q;
      if (!phase && state == S_RD2) cap_yhi <= bus.emu_q;
      if (state == S_CAP) begin
        bus.xout <= cap_x;
        bus.yout <= {cap_yhi, bus.emu_q};
      end
    end
  end

endmodule

// File: tb/tb_fir_emu_master.sv
// tb/tb_fir_emu_master.sv - wrapper/PE models around DUT_CYCLES=1 and DUT_CYCLES=3 instances
module tb_fir_emu_master;
  import fir_emu_pkg::*;

  typedef struct {
    logic [7:0]  c;
    logic [7:0]  x;
    logic [15:0] y;
    logic [7:0]  ex;
    logic [15:0] ey;
  } vec_t;

  localparam logic [45:0] RESET_SNAP = {1'b1, 45'd0};

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  cin = '0;
  logic [7:0]  xin = '0;
  logic [15:0] yin = '0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int DC = (g == 0) ? 1 : 3;

    fir_emu_master_if bus();
    fir_emu_master #(.DUT_CYCLES(DC)) u_dut (.clk(clk), .rst(rst), .bus(bus));

    logic [7:0]  in_reg [4];
    logic [7:0]  out_reg [4];
    logic [7:0]  q_reg = '0;
    logic [7:0]  pe_c = '0, pe_x = '0, pe_xo = '0;
    logic [15:0] pe_y = '0, pe_yo = '0;
    int          dclk_n = 0;
    int          viol = 0;
    int          wl_n = 0;
    logic [15:0] wl [256];
    logic [45:0] snap;

    assign bus.start = start;
    assign bus.cin   = cin;
    assign bus.xin   = xin;
    assign bus.yin   = yin;
    assign bus.emu_q = q_reg;
    assign snap = {bus.ready, bus.done, bus.xout, bus.yout, bus.emu_data, bus.emu_addr,
                   bus.emu_load, bus.emu_get, bus.emu_clk, bus.dut_clk};

    always @(posedge clk) begin
      if (bus.emu_clk) begin
        if (bus.emu_load) begin
          pe_c <= in_reg[0];
          pe_x <= in_reg[1];
          pe_y <= {in_reg[2], in_reg[3]};
        end else if (bus.emu_get) begin
          out_reg[0] <= pe_xo;
          out_reg[1] <= pe_yo[15:8];
          out_reg[2] <= pe_yo[7:0];
          out_reg[3] <= 8'h00;
        end else begin
          in_reg[bus.emu_addr[1:0]] <= bus.emu_data;
          q_reg <= out_reg[bus.emu_addr[1:0]];
        end
      end
      if (bus.dut_clk) begin
        pe_xo <= pe_x;
        pe_yo <= pe_y + 16'(pe_c) * 16'(pe_x);
      end
    end

    always @(negedge clk) begin
      if (bus.dut_clk) dclk_n++;
      if ((bus.emu_load && bus.emu_get) || (bus.emu_clk && bus.dut_clk) || bus.emu_addr > 8'd3)
        viol++;
      if (bus.emu_clk && !bus.emu_load && !bus.emu_get) begin
        wl[wl_n[7:0]] = {bus.emu_addr, bus.emu_data};
        wl_n++;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Runs one transaction; inputs are scrambled one cycle after acceptance.
  task automatic run_txn(input logic [7:0] c, input logic [7:0] x, input logic [15:0] y,
                         input bit hold, output int t0, output int t1, output int n0,
                         output bit stable, output logic rdy_mid);
    logic [23:0] prev;
    @(negedge clk);
    cin = c; xin = x; yin = y; start = 1'b1;
    prev = {g_dut[0].bus.xout, g_dut[0].bus.yout};
    t0 = 0; t1 = 0; n0 = 0; stable = 1'b1; rdy_mid = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk); #1;
      if (n == 1) begin cin = ~c; xin = ~x; yin = ~y; end
      if (n == 10) rdy_mid = g_dut[0].bus.ready;
      if (g_dut[0].bus.done) begin
        n0++;
        if (t0 == 0) t0 = n;
      end
      if (g_dut[1].bus.done && t1 == 0) t1 = n;
      if (t0 == 0 && {g_dut[0].bus.xout, g_dut[0].bus.yout} != prev) stable = 1'b0;
    end
    start = 1'b0;
  endtask

  task automatic verify_txn(input vec_t v, input bit hold);
    int t0, t1, n0, b, p0, p1;
    bit stable;
    logic rdy_mid;
    logic [63:0] wr_act;
    logic [47:0] rd_act;
    b  = g_dut[0].wl_n;
    p0 = g_dut[0].dclk_n;
    p1 = g_dut[1].dclk_n;
    run_txn(v.c, v.x, v.y, hold, t0, t1, n0, stable, rdy_mid);
    wr_act = '0;
    rd_act = '0;
    for (int k = 0; k < 4; k++) begin
      int idx = b + k;
      wr_act = {wr_act[47:0], g_dut[0].wl[idx[7:0]]};
    end
    for (int k = 4; k < 7; k++) begin
      int idx = b + k;
      rd_act = {rd_act[31:0], g_dut[0].wl[idx[7:0]]};
    end
    check("done_cycle_dc1", 64'(t0), 64'd21);
    check("done_cycle_dc3", 64'(t1), 64'd25);
    check("done_count_dc1", 64'(n0), 64'd1);
    check("ready_mid", 64'(rdy_mid), 64'd0);
    check("result_dc1", {g_dut[0].bus.xout, g_dut[0].bus.yout}, {v.ex, v.ey});
    check("result_dc3", {g_dut[1].bus.xout, g_dut[1].bus.yout}, {v.ex, v.ey});
    check("hold_until_done", 64'(stable), 64'd1);
    check("dut_pulses_dc1", 64'(g_dut[0].dclk_n - p0), 64'd1);
    check("dut_pulses_dc3", 64'(g_dut[1].dclk_n - p1), 64'd3);
    check("write_log", wr_act, {8'd0, v.c, 8'd1, v.x, 8'd2, v.y[15:8], 8'd3, v.y[7:0]});
    check("read_log", rd_act, 48'h0000_0100_0200);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    vec_t vt[6];
    int   nd;
    vt[0] = '{8'h03, 8'h05, 16'h0010, 8'h05, 16'h001F};
    vt[1] = '{8'hFF, 8'hFF, 16'h0001, 8'hFF, 16'hFE02};
    vt[2] = '{8'h00, 8'h7A, 16'h1234, 8'h7A, 16'h1234};
    vt[3] = '{8'h10, 8'h10, 16'h0F00, 8'h10, 16'h1000};
    vt[4] = '{8'h80, 8'h02, 16'h8000, 8'h02, 16'h8100};
    vt[5] = '{8'h0C, 8'h0B, 16'h00AA, 8'h0B, 16'h012E};

    #2 rst = 1'b1;
    #1;
    check("reset_outputs_dc1", 64'(g_dut[0].snap), 64'(RESET_SNAP));
    check("reset_outputs_dc3", 64'(g_dut[1].snap), 64'(RESET_SNAP));
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) verify_txn(vt[i], 1'b0);

    // start held high through the whole window
    verify_txn('{8'h01, 8'h02, 16'h0003, 8'h02, 16'h0005}, 1'b1);
    do_reset();

    // abort in RD1 SETUP: 16 edges after acceptance
    @(negedge clk);
    cin = 8'h09; xin = 8'h09; yin = 16'h0009; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_outputs_dc1", 64'(g_dut[0].snap), 64'(RESET_SNAP));
    check("abort_outputs_dc3", 64'(g_dut[1].snap), 64'(RESET_SNAP));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    nd = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (g_dut[0].bus.done || g_dut[1].bus.done) nd++;
    end
    check("no_done_after_abort", 64'(nd), 64'd0);
    verify_txn('{8'h02, 8'h04, 16'h0000, 8'h04, 16'h0008}, 1'b0);

    check("exclusive_strobes_dc1", 64'(g_dut[0].viol), 64'd0);
    check("exclusive_strobes_dc3", 64'(g_dut[1].viol), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_emu_master.md
FIR_EMU_MASTER -- requirements
Module: fir_emu_master

Interface
REQ-001 Parameter DUT_CYCLES, default 1: number of dut_clk pulses issued per transaction, legal range 1..15.
REQ-002 clk  input  1  single system clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  transaction request; accepted only while ready=1.
REQ-005 cin, xin  input  8 each  coefficient and sample stimulus.
REQ-006 yin  input  16  partial-sum stimulus.
REQ-007 ready  output  1  high only in IDLE.
REQ-008 done  output  1  one-cycle pulse; xout/yout valid from this cycle.
REQ-009 xout  output  8  captured DUT sample output.
REQ-010 yout  output  16  captured DUT partial-sum output.
REQ-011 emu_data  output  8  byte to wrapper Data_In.
REQ-012 emu_q  input  8  byte from wrapper Data_Out.
REQ-013 emu_addr  output  8  wrapper Addr; only values 0..3 ever driven.
REQ-014 emu_load, emu_get  output  1 each  wrapper load_emu / get_emu.
REQ-015 emu_clk  output  1  wrapper clk_emu strobe, registered.
REQ-016 dut_clk  output  1  wrapper clk_dut strobe, registered.

Function
REQ-017 On start with ready=1, the block SHALL latch cin, xin, yin and leave IDLE; start while ready=0 SHALL be ignored.
REQ-018 Every wrapper access SHALL take two cycles: SETUP (emu_clk=0, addr/data/load/get driven) then STROBE (emu_clk=1, same values held).
REQ-019 State sequence SHALL be IDLE, WR0..WR3, LOAD, DCLK, GET, RD0..RD2, CAP, DONE, IDLE.
REQ-020 WRk SHALL drive emu_addr=k with emu_data = cin, xin, yin[15:8], yin[7:0] for k=0..3, emu_load=0, emu_get=0.
REQ-021 LOAD SHALL drive emu_load=1, emu_get=0, emu_addr=0, emu_data=0.
REQ-022 DCLK SHALL produce DUT_CYCLES pulses, each one cycle dut_clk=1 then one cycle dut_clk=0; emu_clk stays 0.
REQ-023 GET SHALL drive emu_get=1, emu_load=0, emu_addr=0, emu_data=0.
REQ-024 RDk SHALL drive emu_addr=k, emu_data=0; the byte for address k SHALL be sampled from emu_q in the SETUP cycle following that access's STROBE (RD1 SETUP, RD2 SETUP, CAP).
REQ-025 Captured bytes SHALL map to xout, yout[15:8], yout[7:0] for addresses 0, 1, 2.
REQ-026 CAP is one cycle with emu_clk=0; DONE asserts done=1 for exactly one cycle, then the block returns to IDLE.
REQ-027 done SHALL assert exactly 2*(9+DUT_CYCLES)+1 cycles after the start-accept edge (21 cycles for DUT_CYCLES=1).
REQ-028 emu_load and emu_get SHALL never be high simultaneously, and dut_clk and emu_clk SHALL never be high simultaneously.
REQ-029 xout/yout SHALL hold their last captured value until the next DONE; they are not updated mid-transaction.
REQ-030 Outside DCLK, dut_clk=0; outside STROBE cycles, emu_clk=0.

Reset
REQ-031 rst SHALL force IDLE immediately: ready=1, done=0, xout=0, yout=0, emu_data=0, emu_addr=0, emu_load=0, emu_get=0, emu_clk=0, dut_clk=0, DUT-pulse counter=0.
REQ-032 Reset mid-transaction SHALL abort without a done pulse; the first start after reset release SHALL run a full sequence.

Structure
REQ-033 Shared package fir_emu_pkg SHALL hold the state enumeration, address constants (ADDR_CIN=0, ADDR_XIN=1, ADDR_YHI=2, ADDR_YLO=3, ADDR_XOUT=0, ADDR_YOUT_HI=1, ADDR_YOUT_LO=2), and byte/word widths.
REQ-034 No sub-module: FSM, phase bit, DUT-pulse counter and capture registers SHALL be in one module.

Verification
REQ-035 Bench with wrapper model and fir_pe model (Yout=Yin+Cin*Xin, Xout=Xin, registered on dut_clk): cin=0x03, xin=0x05, yin=0x0010 -> done at cycle 21, xout=0x05, yout=0x001F.
REQ-036 cin=0xFF, xin=0xFF, yin=0x0001 -> yout=0xFE02, xout=0xFF; write log shows addr/data 0/FF, 1/FF, 2/00, 3/01 in order.
REQ-037 start held high through a transaction -> exactly one done per IDLE entry; inputs changed mid-transaction do not affect emu_data.
REQ-038 rst asserted during RD1 -> all outputs zero asynchronously, no done; next start with cin=0x02, xin=0x04, yin=0x0000 -> yout=0x0008.
REQ-039 DUT_CYCLES=3 -> three dut_clk pulses, done at cycle 25; assertion monitor confirms REQ-028 throughout.
